// File: rtl/hp_pkg.sv
// Shared HP definitions: state enum, HP width, display ceiling and saturating helpers.
package hp_pkg;

  localparam int HP_W = 4;
  localparam logic [HP_W-1:0] HP_DISPLAY_MAX = 4'd10;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_INV   = 2'd1,
    ST_DEAD  = 2'd2
  } hp_state_e;

  // Damage amount 0 counts as 1; the borrow bit of the 5-bit difference flags underflow.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [1:0] amt);
    logic [HP_W:0] amt_ext;
    logic [HP_W:0] diff;
    amt_ext = (amt == 2'd0) ? {{HP_W{1'b0}}, 1'b1} : {{(HP_W-1){1'b0}}, amt};
    diff    = {1'b0, hp} - amt_ext;
    return diff[HP_W] ? '0 : diff[HP_W-1:0];
  endfunction

  function automatic logic [HP_W-1:0] sat_inc(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] max_hp);
    logic [HP_W:0] sum;
    sum = {1'b0, hp} + {{HP_W{1'b0}}, 1'b1};
    return (sum > {1'b0, max_hp}) ? max_hp : sum[HP_W-1:0];
  endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector: registers the input once and flags in=1 while prev=0.
module edge_det (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= din;
    end
  end

  assign rise = din & ~prev_reg;

endmodule

// File: rtl/hp_counter.sv
// Hit-point keeper: saturating HP with post-hit invulnerability, timed regen and a dead state.
module hp_counter
  import hp_pkg::*;
#(
  parameter logic [HP_W-1:0] HP_MAX     = HP_DISPLAY_MAX,
  parameter logic [HP_W-1:0] HP_INIT    = 4'd5,
  parameter logic [23:0]     INVULN_CYC = 24'd12_000_000,
  parameter logic [27:0]     REGEN_CYC  = 28'd60_000_000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DAMAGE,
  input  logic [1:0]      DMG_AMT,
  input  logic            HEAL,
  input  logic            REVIVE,
  output logic [HP_W-1:0] OUT_HP,
  output logic            DEAD,
  output logic            INVULN,
  output logic            HIT
);

  logic [2:0] ev_in;
  logic [2:0] ev_rise;
  logic       dmg_rise;
  logic       heal_rise;
  logic       revive_rise;

  assign ev_in = {REVIVE, HEAL, DAMAGE};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      edge_det u_edge (
        .clk  (CLK),
        .srst (RST),
        .din  (ev_in[gi]),
        .rise (ev_rise[gi])
      );
    end
  endgenerate

  assign dmg_rise    = ev_rise[0];
  assign heal_rise   = ev_rise[1];
  assign revive_rise = ev_rise[2];

  hp_state_e       state_reg;
  logic [HP_W-1:0] hp_reg;
  logic [23:0]     inv_timer_reg;
  logic [27:0]     regen_cnt_reg;
  logic            hit_reg;
  logic            dead_reg;
  logic            invuln_reg;

  logic [HP_W-1:0] hp_after_dmg;
  logic [HP_W-1:0] hp_plus_one;
  logic            regen_due;
  logic            hp_full;

  assign hp_after_dmg = sat_sub(hp_reg, DMG_AMT);
  assign hp_plus_one  = sat_inc(hp_reg, HP_MAX);
  assign regen_due    = (regen_cnt_reg == REGEN_CYC - 28'd1);
  assign hp_full      = (hp_reg >= HP_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_ALIVE;
      hp_reg        <= HP_INIT;
      inv_timer_reg <= '0;
      regen_cnt_reg <= '0;
      hit_reg       <= 1'b0;
      dead_reg      <= 1'b0;
      invuln_reg    <= 1'b0;
    end else begin
      hit_reg <= 1'b0;
      case (state_reg)
        ST_ALIVE: begin
          // Damage outranks heal and regen; a heal in the same cycle is dropped.
          if (dmg_rise) begin
            hp_reg        <= hp_after_dmg;
            hit_reg       <= 1'b1;
            regen_cnt_reg <= '0;
            if (hp_after_dmg == '0) begin
              state_reg <= ST_DEAD;
              dead_reg  <= 1'b1;
            end else begin
              state_reg     <= ST_INV;
              invuln_reg    <= 1'b1;
              inv_timer_reg <= INVULN_CYC - 24'd1;
            end
          end else if (heal_rise) begin
            hp_reg        <= hp_plus_one;
            regen_cnt_reg <= '0;
          end else if (hp_full) begin
            regen_cnt_reg <= '0;
          end else if (regen_due) begin
            hp_reg        <= hp_plus_one;
            regen_cnt_reg <= '0;
          end else begin
            regen_cnt_reg <= regen_cnt_reg + 28'd1;
          end
        end

        ST_INV: begin
          // Damage edges are swallowed here; heals still land.
          if (heal_rise) begin
            hp_reg        <= hp_plus_one;
            regen_cnt_reg <= '0;
          end
          if (inv_timer_reg == '0) begin
            state_reg     <= ST_ALIVE;
            invuln_reg    <= 1'b0;
            regen_cnt_reg <= '0;
          end else begin
            inv_timer_reg <= inv_timer_reg - 24'd1;
          end
        end

        ST_DEAD: begin
          if (revive_rise) begin
            state_reg     <= ST_ALIVE;
            dead_reg      <= 1'b0;
            hp_reg        <= HP_INIT;
            regen_cnt_reg <= '0;
          end else begin
            hp_reg <= '0;
          end
        end

        default: begin
          state_reg     <= ST_ALIVE;
          hp_reg        <= HP_INIT;
          inv_timer_reg <= '0;
          regen_cnt_reg <= '0;
          dead_reg      <= 1'b0;
          invuln_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign OUT_HP = hp_reg;
  assign DEAD   = dead_reg;
  assign INVULN = invuln_reg;
  assign HIT    = hit_reg;

endmodule
